// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// Contents: datapath width, register file geometry, opcode encoding,
// FSM state type and the decoded instruction record.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);

    // 0..6 go to the ALU untouched; 7 is unused by the ALU and is
    // handled locally as a load-immediate.
    typedef enum logic [2:0] {
        OP_ALU0  = 3'd0,
        OP_ALU1  = 3'd1,
        OP_ALU2  = 3'd2,
        OP_ALU3  = 3'd3,
        OP_ALU4  = 3'd4,
        OP_ALU5  = 3'd5,
        OP_ALU6  = 3'd6,
        OP_LOADI = 3'd7
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [AW-1:0]    rd;
        logic [AW-1:0]    rs1;
        logic [AW-1:0]    rs2;
        logic             cin;
        logic [WIDTH-1:0] imm;
    } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue stage.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all entries)
//   we, waddr, wdata    synchronous write port
//   raddr1 -> rdata1    combinational read port (ALU operand a)
//   raddr2 -> rdata2    combinational read port (ALU operand b)
//   dbg_addr -> dbg_data combinational debug read port
module alu_regfile
    import alu_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int N  = NREGS,
    parameter int A  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [A-1:0] raddr1,
    output logic [W-1:0] rdata1,
    input  logic [A-1:0] raddr2,
    output logic [W-1:0] rdata2,
    input  logic [A-1:0] dbg_addr,
    output logic [W-1:0] dbg_data
);

    logic [W-1:0] r_mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1   = r_mem[raddr1];
    assign rdata2   = r_mem[raddr2];
    assign dbg_data = r_mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer sitting directly in front of the 16-bit ALU.
// Accepts one instruction at a time, presents registered operands to the
// ALU for one cycle, then writes the ALU result and flags back. Opcode 7
// (LOADI) is executed locally in a single cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an instruction; LOADI completes here in one cycle
// EXEC  | ALU operands on the bus; result written back at the end edge
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   instruction handshake
//   in_opcode, in_rd, in_rs1, in_rs2,
//   in_cin, in_imm                      instruction fields
//   alu_a, alu_b, alu_cin, alu_opcode   registered ALU inputs
//   alu_w, alu_zero, alu_neg            ALU result and flags
//   zero_flag, neg_flag                 flags of the last written result
//   done                                one-cycle pulse after a writeback
//   instr_cnt                           completed instructions (wraps)
//   dbg_addr -> dbg_data                combinational register file peek
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREGS = alu_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_rs1,
    input  logic [2:0]       in_rs2,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             done,
    output logic [15:0]      instr_cnt,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           r_state;
    logic             r_ready;
    logic [2:0]       r_rd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_alu_cin;
    logic [2:0]       r_alu_opcode;
    logic             r_zero;
    logic             r_neg;
    logic             r_done;
    logic [15:0]      r_cnt;

    instr_t           w_instr;
    logic             w_accept;
    logic             w_loadi;
    logic             w_we;
    logic [2:0]       w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;

    assign w_instr  = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        cin: in_cin, imm: in_imm};
    assign w_accept = in_valid && r_ready && (r_state == IDLE);
    assign w_loadi  = (w_instr.opcode == OP_LOADI);

    // Two writers share the single write port: LOADI at its accept edge,
    // and the ALU result at the end of EXEC. They can never coincide
    // because nothing is accepted while in EXEC.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_rd;
        w_wdata = alu_w;
        if (r_state == EXEC) begin
            w_we = 1'b1;
        end else if (w_accept && w_loadi) begin
            w_we    = 1'b1;
            w_waddr = w_instr.rd;
            w_wdata = w_instr.imm;
        end
    end

    alu_regfile #(
        .W (WIDTH),
        .N (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_we),
        .waddr    (w_waddr),
        .wdata    (w_wdata),
        .raddr1   (w_instr.rs1),
        .rdata1   (w_rdata1),
        .raddr2   (w_instr.rs2),
        .rdata2   (w_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // in_ready is registered: it reflects the state the FSM will be in,
    // so it drops in the same edge that enters EXEC and stays low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_rd         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cin    <= 1'b0;
            r_alu_opcode <= '0;
            r_zero       <= 1'b0;
            r_neg        <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_rd <= w_instr.rd;
                        if (w_loadi) begin
                            r_zero <= (w_instr.imm == '0);
                            r_neg  <= w_instr.imm[WIDTH-1];
                            r_done <= 1'b1;
                            r_cnt  <= r_cnt + 16'd1;
                        end else begin
                            r_alu_a      <= w_rdata1;
                            r_alu_b      <= w_rdata2;
                            r_alu_cin    <= w_instr.cin;
                            r_alu_opcode <= w_instr.opcode;
                            r_ready      <= 1'b0;
                            r_state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_zero  <= alu_zero;
                    r_neg   <= alu_neg;
                    r_done  <= 1'b1;
                    r_cnt   <= r_cnt + 16'd1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_cin    = r_alu_cin;
    assign alu_opcode = r_alu_opcode;
    assign zero_flag  = r_zero;
    assign neg_flag   = r_neg;
    assign done       = r_done;
    assign instr_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a stub ALU (w = a + b + cin).
// Expected writebacks are queued at issue time and checked when done pulses.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_cin;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_w;
    logic        alu_zero;
    logic        alu_neg;
    logic        zero_flag;
    logic        neg_flag;
    logic        done;
    logic [15:0] instr_cnt;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        z;
        logic        n;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] m_rf [8];
    logic [15:0] mon_cnt = '0;
    logic        mon_sel = 1'b0;
    logic [2:0]  mon_addr = '0;
    logic [2:0]  stim_addr = '0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          waits;

    always #5 clk = ~clk;

    assign alu_w    = alu_a + alu_b + {15'b0, alu_cin};
    assign alu_zero = (alu_w == 16'h0000);
    assign alu_neg  = alu_w[15];
    assign dbg_addr = mon_sel ? mon_addr : stim_addr;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_cin     (in_cin),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_opcode (alu_opcode),
        .alu_w      (alu_w),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
        .done       (done),
        .instr_cnt  (instr_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Holds the instruction until accepted,
    // records the expected writeback, and returns at the falling edge
    // after the accept edge (inside EXEC for ALU ops).
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic cin, input logic [15:0] imm,
                         output int nwait);
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_cin    = cin;
        in_imm    = imm;
        nwait     = 0;
        while (!in_ready && nwait < 20) begin
            @(negedge clk);
            nwait++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        a = m_rf[rs1];
        b = m_rf[rs2];
        if (op == 3'd7) e.data = imm;
        else            e.data = a + b + {15'b0, cin};
        e.rd = rd;
        e.z  = (e.data == 16'h0000);
        e.n  = e.data[15];
        m_rf[rd] = e.data;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (op != 3'd7) begin
            chk("exec_alu_a", {16'b0, alu_a}, {16'b0, a});
            chk("exec_alu_b", {16'b0, alu_b}, {16'b0, b});
            chk("exec_alu_cin", {31'b0, alu_cin}, {31'b0, cin});
            chk("exec_alu_opcode", {29'b0, alu_opcode}, {29'b0, op});
            chk("exec_in_ready", {31'b0, in_ready}, 32'd0);
        end
    endtask

    // Writeback monitor: every done pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_cnt = '0;
        end else if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                mon_cnt = mon_cnt + 16'd1;
                mon_addr = mon_e.rd;
                mon_sel = 1'b1;
                #1;
                chk("wb_data", {16'b0, dbg_data}, {16'b0, mon_e.data});
                chk("wb_zero", {31'b0, zero_flag}, {31'b0, mon_e.z});
                chk("wb_neg", {31'b0, neg_flag}, {31'b0, mon_e.n});
                chk("wb_instr_cnt", {16'b0, instr_cnt}, {16'b0, mon_cnt});
                mon_sel = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_opcode = 3'd7;
        in_rd     = 3'd1;
        in_rs1    = 3'd0;
        in_rs2    = 3'd0;
        in_cin    = 1'b0;
        in_imm    = 16'h1234;

        // Reset with in_valid held high
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_alu_a", {16'b0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'b0, alu_b}, 32'd0);
        chk("rst_alu_cin", {31'b0, alu_cin}, 32'd0);
        chk("rst_alu_opcode", {29'b0, alu_opcode}, 32'd0);
        chk("rst_flags", {30'b0, zero_flag, neg_flag}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_instr_cnt", {16'b0, instr_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            stim_addr = 3'(i);
            #1;
            chk("rst_dbg_data", {16'b0, dbg_data}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // LOADI burst on consecutive cycles
        issue(3'd7, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005, waits);
        issue(3'd7, 3'd2, 3'd0, 3'd0, 1'b0, 16'h8000, waits);
        chk("loadi_b2b_wait", waits, 32'd0);

        // ALU op: r3 = r1 + r2 + 1 = 0x8006
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0000, waits);

        // Zero result with in-place update of r4
        issue(3'd7, 3'd4, 3'd0, 3'd0, 1'b0, 16'hFFFF, waits);
        chk("post_exec_wait", waits, 32'd1);
        issue(3'd7, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0001, waits);
        issue(3'd0, 3'd4, 3'd4, 3'd5, 1'b0, 16'h0000, waits);

        // Stall: second ALU op held valid through EXEC of the first
        issue(3'd1, 3'd6, 3'd3, 3'd3, 1'b0, 16'h0000, waits);
        issue(3'd2, 3'd7, 3'd6, 3'd1, 1'b1, 16'h0000, waits);
        chk("stall_wait", waits, 32'd1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue", q.size(), 32'd0);
        chk("total_instr_cnt", {16'b0, instr_cnt}, 32'd8);
        stim_addr = 3'd4;
        #1;
        chk("r4_zero", {16'b0, dbg_data}, 32'd0);
        chk("zero_flag_set", {31'b0, zero_flag}, {31'b0, 1'b0});
        @(negedge clk);

        // Async reset during EXEC aborts the writeback to r0
        issue(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, waits);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_alu_a", {16'b0, alu_a}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_instr_cnt", {16'b0, instr_cnt}, 32'd0);
        chk("abort_flags", {30'b0, zero_flag, neg_flag}, 32'd0);
        q.delete();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        stim_addr = 3'd0;
        #1;
        chk("abort_r0", {16'b0, dbg_data}, 32'd0);
        chk("abort_post_cnt", {16'b0, instr_cnt}, 32'd0);
        chk("abort_post_done", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream of the 16-bit behavioural ALU (ports a, b, cin, opcode, w, zero, neg). Also consumes the ALU's result.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Presents the operands to the ALU for one cycle, then writes the ALU result and flags back.
- Opcode 7, which the ALU does not use, is a load-immediate handled locally.

Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- NREGS, 8, register file depth; address width is log2(NREGS) = 3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept an instruction
- in_opcode  in  3  0..6 are ALU ops; 7 is LOADI
- in_rd  in  3  destination register
- in_rs1  in  3  source for ALU port a
- in_rs2  in  3  source for ALU port b
- in_cin  in  1  carry-in passed to the ALU
- in_imm  in  WIDTH  immediate, used only by LOADI
- alu_a  out  WIDTH  ALU operand a (registered)
- alu_b  out  WIDTH  ALU operand b (registered)
- alu_cin  out  1  ALU carry-in (registered)
- alu_opcode  out  3  ALU opcode (registered)
- alu_w  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_cin/alu_opcode
- alu_zero  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- zero_flag  out  1  last written result was zero
- neg_flag  out  1  last written result was negative
- done  out  1  one-cycle pulse on the cycle after a writeback
- instr_cnt  out  16  completed instructions; wraps 0xFFFF -> 0
- dbg_addr  in  3  debug read address
- dbg_data  out  WIDTH  rf[dbg_addr], combinational, reflects writes after the edge

Behaviour:
- Reset (async, rst_n=0):
  - rf all zero; alu_a, alu_b, alu_cin, alu_opcode = 0.
  - zero_flag=0, neg_flag=0, done=0, instr_cnt=0; state=IDLE.
  - in_ready is 0 while rst_n=0.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid & in_ready, latch rd and opcode.
  - For opcode 0..6:
    - load alu_a=rf[rs1], alu_b=rf[rs2], alu_cin=in_cin, alu_opcode=in_opcode at the same edge.
    - go to EXEC.
  - For opcode 7 (LOADI):
    - write rf[rd]=in_imm at that same edge.
    - zero_flag=(in_imm==0), neg_flag=in_imm[WIDTH-1].
    - done=1 next cycle; instr_cnt+1; stay in IDLE.
    - ALU outputs hold their previous values.
    - Back-to-back LOADIs are accepted every cycle.
- EXEC:
  - in_ready=0 for exactly one cycle.
  - At the ending edge: rf[rd]=alu_w, zero_flag=alu_zero, neg_flag=alu_neg, done=1 the next cycle, instr_cnt+1, go to IDLE.
  - ALU outputs hold until the next ALU instruction is accepted.
- Throughput: an ALU instruction costs 2 cycles, a LOADI costs 1.
- Latency: accept edge T0 -> writeback edge T1 -> done high during the T1..T2 cycle.
- Operand read uses the register values at the accept edge. No hazard is possible because the block holds only one instruction in flight.
- rs1==rs2 and rd==rs1 are legal. Sources are read before the writeback.
- in_valid while in EXEC: ignored, not lost; the upstream holds it until in_ready.
- Reset asserted during EXEC aborts the instruction: no writeback, no done.
- done is not sticky. It is 0 in every cycle without a writeback.

Decomposition:
- Package alu_pkg:
  - WIDTH.
  - Opcode enum with OP_LOADI=3'd7.
  - state_t {IDLE, EXEC}.
  - An instr_t struct {opcode, rd, rs1, rs2, cin, imm}.
- One sub-module, alu_regfile: 8xWIDTH, two combinational read ports plus the debug port, one synchronous write port, async reset clear.
- The FSM lives in alu_issue_ctrl.
- The top-level bench instantiates alu_issue_ctrl driving the ALU module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0; all outputs 0; every dbg_data read = 0.
- LOADI burst:
  - Stimulus: LOADI r1=0x0005, then LOADI r2=0x8000, on consecutive cycles.
  - Response: dbg r1=0x0005, r2=0x8000; done high 2 cycles; instr_cnt=2; final neg_flag=1, zero_flag=0.
- ALU issue (the stub ALU returns a+b+cin):
  - Stimulus: op0 rd=3 rs1=1 rs2=2 cin=1.
  - Response: alu_a=0x0005, alu_b=0x8000 in EXEC; in_ready=0 one cycle; r3=0x8006; done one cycle later.
- Zero result, in-place update (same stub):
  - Stimulus: LOADI r4=0xFFFF, LOADI r5=0x0001, then op0 rd=4 rs1=4 rs2=5 cin=0.
  - Response: r4=0x0000; zero_flag follows alu_zero=1.
- Stall:
  - Stimulus: in_valid held high through EXEC with a second instruction.
  - Response: that instruction is accepted only on the cycle after EXEC; instr_cnt increments exactly once per instruction.
- Async reset mid-EXEC: drop rst_n between edges -> outputs clear immediately; rd is unchanged (0); done is never asserted.
